// File: rtl/dispatch_nway.sv
// N-wide dispatch: accepts an in-order prefix of renamed lanes within ROB/SQ/IQ space,
// stamps ROB/SQ indices from owned enqueue pointers, and holds the group for IQ/ROB/SQ.
module dispatch_nway #(
  parameter int WIDTH     = 2,
  parameter int PAYLOAD_W = 256,
  parameter int ROB_LOG   = 6,
  parameter int SQ_LOG    = 4,
  parameter int IQ_CNT_W  = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in_valid,
  output logic [WIDTH-1:0]             in_ready,
  input  logic [WIDTH*PAYLOAD_W-1:0]   in_payload,
  input  logic [WIDTH-1:0]             in_is_store,
  input  logic [ROB_LOG:0]             rob_free_cnt,
  input  logic [SQ_LOG:0]              sq_free_cnt,
  input  logic [IQ_CNT_W-1:0]          iq_free_cnt,
  input  logic                         rob_walk_busy,
  output logic [WIDTH-1:0]             out_valid,
  input  logic                         out_ready,
  output logic [WIDTH*PAYLOAD_W-1:0]   out_payload,
  output logic [WIDTH-1:0]             out_is_store,
  output logic [WIDTH*ROB_LOG-1:0]     out_robidx,
  output logic [WIDTH-1:0]             out_robidx_flag,
  output logic [WIDTH*SQ_LOG-1:0]      out_sqidx,
  output logic [WIDTH-1:0]             out_sqidx_flag,
  input  logic                         flush_valid,
  input  logic [ROB_LOG-1:0]           flush_robidx,
  input  logic                         flush_robidx_flag,
  input  logic [SQ_LOG-1:0]            flush_sqidx,
  input  logic                         flush_sqidx_flag
);

  localparam int CW = 16;
  localparam int HW = 3;

  logic [WIDTH-1:0]           out_valid_q, out_valid_d;
  logic [WIDTH*PAYLOAD_W-1:0] out_payload_q, out_payload_d;
  logic [WIDTH-1:0]           out_is_store_q, out_is_store_d;
  logic [WIDTH*ROB_LOG-1:0]   out_robidx_q, out_robidx_d;
  logic [WIDTH-1:0]           out_robidx_flag_q, out_robidx_flag_d;
  logic [WIDTH*SQ_LOG-1:0]    out_sqidx_q, out_sqidx_d;
  logic [WIDTH-1:0]           out_sqidx_flag_q, out_sqidx_flag_d;
  logic [ROB_LOG:0]           rob_ptr_q, rob_ptr_d;
  logic [SQ_LOG:0]            sq_ptr_q, sq_ptr_d;
  logic [HW-1:0]              held_n_q, held_n_d, held_st_q, held_st_d;

  logic [CW-1:0]              e_rob_s, e_iq_s, e_sq_s;
  logic                       can_load_s;
  logic [WIDTH-1:0]           ready_s;
  logic                       fire_s;

  function automatic logic [CW-1:0] sat_sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
    if (a > b) return a - b;
    else       return {CW{1'b0}};
  endfunction

  // Free space seen by this stage: the held group still occupies downstream slots.
  always_comb begin
    e_rob_s    = sat_sub(CW'(rob_free_cnt), CW'(held_n_q));
    e_iq_s     = sat_sub(CW'(iq_free_cnt),  CW'(held_n_q));
    e_sq_s     = sat_sub(CW'(sq_free_cnt),  CW'(held_st_q));
    can_load_s = ~reset & ~flush_valid & ~rob_walk_busy & (~|out_valid_q | out_ready);
  end

  // Prefix acceptance: each lane needs its predecessor plus room for itself.
  always_comb begin : accept
    logic          lane_ok;
    logic [CW-1:0] st_seen;
    ready_s = {WIDTH{1'b0}};
    lane_ok = can_load_s;
    st_seen = {CW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      st_seen = st_seen + CW'(in_is_store[i]);
      if (lane_ok && in_valid[i] && (CW'(i + 1) <= e_rob_s) && (CW'(i + 1) <= e_iq_s)
          && (st_seen <= e_sq_s)) begin
        ready_s[i] = 1'b1;
      end else begin
        ready_s[i] = 1'b0;
      end
      lane_ok = ready_s[i];
    end
  end

  assign fire_s   = |ready_s;
  assign in_ready = ready_s;

  // Next-state: flush beats load, load beats drain; stamps walk the pointers lane by lane.
  always_comb begin : next_state
    logic [ROB_LOG:0] rob_stamp;
    logic [SQ_LOG:0]  sq_stamp;
    logic [HW-1:0]    n_acc, n_st;
    out_valid_d       = out_valid_q;
    out_payload_d     = out_payload_q;
    out_is_store_d    = out_is_store_q;
    out_robidx_d      = out_robidx_q;
    out_robidx_flag_d = out_robidx_flag_q;
    out_sqidx_d       = out_sqidx_q;
    out_sqidx_flag_d  = out_sqidx_flag_q;
    rob_ptr_d         = rob_ptr_q;
    sq_ptr_d          = sq_ptr_q;
    held_n_d          = held_n_q;
    held_st_d         = held_st_q;
    rob_stamp         = rob_ptr_q;
    sq_stamp          = sq_ptr_q;
    n_acc             = {HW{1'b0}};
    n_st              = {HW{1'b0}};
    if (flush_valid) begin
      out_valid_d = {WIDTH{1'b0}};
      held_n_d    = {HW{1'b0}};
      held_st_d   = {HW{1'b0}};
      rob_ptr_d   = {flush_robidx_flag, flush_robidx} + {{ROB_LOG{1'b0}}, 1'b1};
      sq_ptr_d    = {flush_sqidx_flag, flush_sqidx};
    end else if (fire_s) begin
      for (int i = 0; i < WIDTH; i++) begin
        out_payload_d[i*PAYLOAD_W +: PAYLOAD_W] = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
        out_is_store_d[i]                     = in_is_store[i];
        out_robidx_d[i*ROB_LOG +: ROB_LOG]    = rob_stamp[ROB_LOG-1:0];
        out_robidx_flag_d[i]                  = rob_stamp[ROB_LOG];
        out_sqidx_d[i*SQ_LOG +: SQ_LOG]       = sq_stamp[SQ_LOG-1:0];
        out_sqidx_flag_d[i]                   = sq_stamp[SQ_LOG];
        if (ready_s[i]) begin
          rob_stamp = rob_stamp + {{ROB_LOG{1'b0}}, 1'b1};
          n_acc     = n_acc + {{(HW-1){1'b0}}, 1'b1};
          if (in_is_store[i]) begin
            sq_stamp = sq_stamp + {{SQ_LOG{1'b0}}, 1'b1};
            n_st     = n_st + {{(HW-1){1'b0}}, 1'b1};
          end else begin
            sq_stamp = sq_stamp;
          end
        end else begin
          rob_stamp = rob_stamp;
        end
      end
      out_valid_d = ready_s;
      held_n_d    = n_acc;
      held_st_d   = n_st;
      rob_ptr_d   = rob_stamp;
      sq_ptr_d    = sq_stamp;
    end else if (out_ready) begin
      out_valid_d = {WIDTH{1'b0}};
      held_n_d    = {HW{1'b0}};
      held_st_d   = {HW{1'b0}};
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q       <= {WIDTH{1'b0}};
      out_payload_q     <= {(WIDTH*PAYLOAD_W){1'b0}};
      out_is_store_q    <= {WIDTH{1'b0}};
      out_robidx_q      <= {(WIDTH*ROB_LOG){1'b0}};
      out_robidx_flag_q <= {WIDTH{1'b0}};
      out_sqidx_q       <= {(WIDTH*SQ_LOG){1'b0}};
      out_sqidx_flag_q  <= {WIDTH{1'b0}};
      rob_ptr_q         <= {(ROB_LOG+1){1'b0}};
      sq_ptr_q          <= {(SQ_LOG+1){1'b0}};
      held_n_q          <= {HW{1'b0}};
      held_st_q         <= {HW{1'b0}};
    end else begin
      out_valid_q       <= out_valid_d;
      out_payload_q     <= out_payload_d;
      out_is_store_q    <= out_is_store_d;
      out_robidx_q      <= out_robidx_d;
      out_robidx_flag_q <= out_robidx_flag_d;
      out_sqidx_q       <= out_sqidx_d;
      out_sqidx_flag_q  <= out_sqidx_flag_d;
      rob_ptr_q         <= rob_ptr_d;
      sq_ptr_q          <= sq_ptr_d;
      held_n_q          <= held_n_d;
      held_st_q         <= held_st_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_payload     = out_payload_q;
  assign out_is_store    = out_is_store_q;
  assign out_robidx      = out_robidx_q;
  assign out_robidx_flag = out_robidx_flag_q;
  assign out_sqidx       = out_sqidx_q;
  assign out_sqidx_flag  = out_sqidx_flag_q;

endmodule
